// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive front end: FSM state encoding,
// oversampling constants and the baud divisor helper.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clock cycles per oversample tick.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Small show-ahead byte FIFO. A push while full is dropped and flagged,
// unless a pop happens in the same cycle, in which case both are accepted.
module uart_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head_data,
    output logic       empty,
    output logic       full,
    output logic       drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop_en;
    logic          push_en;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign head_data = mem_q[rptr_q];
    assign pop_en    = pop && !empty;
    assign push_en   = push && (!full || pop_en);
    assign drop      = push && full && !pop_en;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_en) begin
            mem_d[wptr_q] = push_data;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop_en) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers; contents cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receiver (x16 oversampled) feeding a small byte FIFO with a
// valid/ready pop interface. Default frame is 8N1; defining
// UART_RX_PARITY_EN switches to 8E1 with a PARITY state and parity check.
//
// Handshake: rx_valid means the FIFO head on rx_data_out is meaningful; the
// head is consumed at a rising clk edge where rx_valid && rx_ready. rx_valid
// does not depend on rx_ready.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 16_000_000,
    parameter int BAUD       = 1_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       rx_enable,
    output logic [7:0] rx_data_out,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    uart_state_e   state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rxs_q, rxs_d;
    logic          rxs_prev_q, rxs_prev_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    scnt_q, scnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          brk_q, brk_d;
    logic          push_q, push_d;
    logic          frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic          par_err_q, par_err_d;
`endif

    logic tick;
    logic mid;
    logic fall;
    logic fifo_empty;
    logic fifo_full;

    assign tick = (div_cnt_q == '0);
    assign mid  = tick && (scnt_q == 4'(MID_SAMPLE));
    assign fall = rxs_prev_q && !rxs_q;

    // Two-flop synchroniser plus one delayed copy for start-edge detection.
    always_comb begin
        sync1_d    = rxd;
        rxs_d      = sync1_q;
        rxs_prev_d = rxs_q;
    end

    // Receive FSM, tick/sample counters and shift register.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        scnt_d      = scnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        brk_d       = brk_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif

        // Counters run continuously through a frame; each state change happens
        // on a mid-sample so scnt keeps its phase across bits.
        if (state_q != ST_IDLE) begin
            if (tick) begin
                div_cnt_d = DW'(DIV - 1);
                scnt_d    = scnt_q + 4'd1;
            end else begin
                div_cnt_d = div_cnt_q - DW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_enable && fall) begin
                    state_d   = ST_START;
                    div_cnt_d = '0;
                    scnt_d    = 4'd0;
                    bit_cnt_d = 3'd0;
                    brk_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (mid) begin
                    // A high line at mid-start is a glitch: drop silently.
                    state_d = rxs_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (mid) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (mid) begin
                    // Even parity: data bits plus parity bit must have even weight.
                    par_err_d = ^{rxs_q, shift_q};
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (brk_q) begin
                    // Line held low after a bad stop bit: wait for it to release.
                    if (rxs_q) begin
                        state_d = ST_IDLE;
                    end
                end else if (mid) begin
                    if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
                        push_d      = !par_err_q;
                        frame_err_d = par_err_q;
`else
                        push_d      = 1'b1;
`endif
                        state_d     = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        brk_d       = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disabling the receiver aborts any frame without reporting anything.
        if (!rx_enable) begin
            state_d     = ST_IDLE;
            push_d      = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    // Receiver state registers; synchroniser resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            div_cnt_q   <= '0;
            scnt_q      <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            rxs_prev_q  <= rxs_prev_d;
            div_cnt_q   <= div_cnt_d;
            scnt_q      <= scnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            brk_q       <= brk_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (shift_q),
        .pop       (rx_ready),
        .head_data (rx_data_out),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (rx_overrun)
    );

    assign rx_valid     = !fifo_empty;
    assign rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend at 16 clk per bit. Bytes expected to be popped
// are queued when their frames are driven; a monitor compares each pop.
module tb_uart_rx_frontend;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_enable = 1'b1;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_frame_err;
    logic       rx_overrun;

    int n_tests = 0;
    int n_fail = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    int valid_cyc = 0;
    logic [7:0] exp_q[$];

`ifdef UART_RX_PARITY_EN
    localparam int PUSH_LAT = 171;
`else
    localparam int PUSH_LAT = 155;
`endif

    uart_rx_frontend #(
        .CLK_FREQ   (16_000_000),
        .BAUD       (1_000_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rxd          (rxd),
        .rx_enable    (rx_enable),
        .rx_data_out  (rx_data_out),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    // Monitor / scoreboard: sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_frame_err) err_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (rx_valid) valid_cyc++;
            if (rx_valid && rx_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_unexpected: got %02h, required no byte", rx_data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_data_out !== e) begin
                        n_fail++;
                        $display("FAIL pop_data: got %02h, required %02h", rx_data_out, e);
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) wait_clk();
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (16) wait_clk();
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^data) ^ par_flip);
`endif
        send_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) wait_clk();
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", rx_valid); end
        n_tests++; if (rx_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h, required 00", rx_data_out); end
        n_tests++; if (rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b, required 0", rx_frame_err); end
        n_tests++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b, required 0", rx_overrun); end
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        int e0, o0, v0;
        e0 = err_cnt; o0 = ovr_cnt; v0 = valid_cyc;
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(10);
        check_int("basic_valid_cycles", valid_cyc - v0, 1);
        check_int("basic_ferr", err_cnt - e0, 0);
        check_int("basic_ovr", ovr_cnt - o0, 0);
        check_int("basic_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_false_start();
        int e0, v0;
        e0 = err_cnt; v0 = valid_cyc;
        rxd = 1'b0;
        repeat (4) wait_clk();
        idle(40);
        check_int("false_start_valid", valid_cyc - v0, 0);
        check_int("false_start_ferr", err_cnt - e0, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(10);
        check_int("false_start_next", exp_q.size(), 0);
    endtask

    task automatic test_frame_err();
        int e0, v0;
        e0 = err_cnt; v0 = valid_cyc;
        send_frame(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (40) wait_clk();
        idle(20);
        check_int("frame_err_pulses", err_cnt - e0, 1);
        check_int("frame_err_no_push", valid_cyc - v0, 0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        idle(10);
        check_int("frame_err_next", exp_q.size(), 0);
        check_int("frame_err_total", err_cnt - e0, 1);
    endtask

    task automatic test_overrun();
        int o0, e0;
        o0 = ovr_cnt; e0 = err_cnt;
        rx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0);
        end
        idle(5);
        check_int("overrun_before_fifth", ovr_cnt - o0, 0);
        send_frame(8'h05, 1'b1, 1'b0);
        idle(5);
        check_int("overrun_on_fifth", ovr_cnt - o0, 1);
        check_int("overrun_ferr", err_cnt - e0, 0);
        rx_ready = 1'b1;
        idle(10);
        check_int("overrun_drained", exp_q.size(), 0);
        n_tests++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_empty_valid: got %b, required 0", rx_valid); end
    endtask

    task automatic test_full_pop_push();
        int o0;
        o0 = ovr_cnt;
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h70 + 8'(i));
            send_frame(8'h70 + 8'(i), 1'b1, 1'b0);
        end
        exp_q.push_back(8'h77);
        idle(3);
        fork
            send_frame(8'h77, 1'b1, 1'b0);
            begin
                repeat (PUSH_LAT) wait_clk();
                rx_ready = 1'b1;
                wait_clk();
                rx_ready = 1'b0;
            end
        join
        idle(5);
        check_int("full_pop_no_overrun", ovr_cnt - o0, 0);
        check_int("full_pop_remaining", exp_q.size(), 4);
        rx_ready = 1'b1;
        idle(10);
        check_int("full_pop_drained", exp_q.size(), 0);
    endtask

    task automatic test_enable_abort();
        int e0, v0;
        e0 = err_cnt; v0 = valid_cyc;
        rx_ready = 1'b1;
        fork
            send_frame(8'h00, 1'b1, 1'b0);
            begin
                repeat (60) wait_clk();
                rx_enable = 1'b0;
                repeat (3) wait_clk();
                rx_enable = 1'b1;
            end
        join
        idle(20);
        check_int("abort_no_push", valid_cyc - v0, 0);
        check_int("abort_no_ferr", err_cnt - e0, 0);
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, 1'b0);
        idle(10);
        check_int("abort_next", exp_q.size(), 0);
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0;
        rx_ready = 1'b1;
        rxd = 1'b0;
        repeat (40) wait_clk();
        rst_n = 1'b0;
        wait_clk();
        n_tests++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_valid: got %b, required 0", rx_valid); end
        rst_n = 1'b1;
        v0 = valid_cyc; e0 = err_cnt;
        idle(200);
        check_int("reset_mid_no_push", valid_cyc - v0, 0);
        check_int("reset_mid_no_ferr", err_cnt - e0, 0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(10);
        check_int("reset_mid_next", exp_q.size(), 0);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int e0, v0;
        e0 = err_cnt; v0 = valid_cyc;
        rx_ready = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(10);
        check_int("parity_bad_ferr", err_cnt - e0, 1);
        check_int("parity_bad_no_push", valid_cyc - v0, 0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(10);
        check_int("parity_good", exp_q.size(), 0);
        check_int("parity_good_ferr", err_cnt - e0, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_full_pop_push();
        test_enable_abort();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        check_int("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
